// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard and its MD busy timer.
// Scoreboard fields are stored at fixed maximum widths so REG_AW/TNEW_W may vary per instance.
package hazard_pkg;

  localparam int unsigned TNEW_W    = 3;
  localparam int unsigned TUSE_NONE = 7;
  localparam int unsigned CP0_EPC   = 14;

  localparam int unsigned SB_AW_MAX = 8;
  localparam int unsigned SB_TW_MAX = 8;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_op_e;

  typedef struct packed {
    logic                 valid;
    logic [SB_AW_MAX-1:0] dst;
    logic [SB_TW_MAX-1:0] tnew;
    logic                 epc_wr;
    logic                 md_start;
    md_op_e               md_op;
  } sb_entry_t;

  // One pipeline step of ageing; T_new never goes below zero.
  function automatic logic [SB_TW_MAX-1:0] tnew_age(input logic [SB_TW_MAX-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request and stall/busy response bundle of the hazard scoreboard.
// With HAZARD_STATS_EN defined the bundle also carries the stall_cycles counter.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned TNEW_W = 3
);
  logic              d_valid;
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TNEW_W-1:0] d_tuse_rs;
  logic [TNEW_W-1:0] d_tuse_rt;
  logic [REG_AW-1:0] d_dst;
  logic [TNEW_W-1:0] d_tnew;
  logic              d_epc_wr;
  logic              d_eret;
  logic              d_md_use;
  logic              d_md_start;
  logic              d_md_div;
  logic              flush;
  logic              stall;
  logic              md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0]       stall_cycles;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    output d_epc_wr, d_eret, d_md_use, d_md_start, d_md_div, flush,
    input  stall, md_busy, stall_cycles
  );
  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    input  d_epc_wr, d_eret, d_md_use, d_md_start, d_md_div, flush,
    output stall, md_busy, stall_cycles
  );
`else
  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    output d_epc_wr, d_eret, d_md_use, d_md_start, d_md_div, flush,
    input  stall, md_busy
  );
  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
    input  d_epc_wr, d_eret, d_md_use, d_md_start, d_md_div, flush,
    output stall, md_busy
  );
`endif
endinterface

// File: rtl/md_busy_timer.sv
// HI/LO busy countdown: loads the mul/div latency when a start sits in E, then counts to zero.
// busy_o also covers the cycle the start itself occupies E.
module md_busy_timer #(
  parameter  int unsigned MUL_CYCLES = 5,
  parameter  int unsigned DIV_CYCLES = 10,
  localparam int unsigned CntW =
    $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            is_div_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic [CntW-1:0] count_o
);

  logic [CntW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (start_i && !abort_i) begin
      count_d = is_div_i ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o  = start_i | (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: shift-register scoreboard of in-flight destinations plus HI/LO busy timer.
// Define HAZARD_STATS_EN to add the 32-bit stall_cycles counter to the interface.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned TNEW_W     = 3,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned CntW =
    $clog2(((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1);

  sb_entry_t entry_d [NUM_STAGES];
  sb_entry_t entry_q [NUM_STAGES];

  logic [REG_AW-1:0] rs, rt;
  logic [TNEW_W-1:0] tuse_rs, tuse_rt;
  logic              hazard, stall, md_start_e, tmr_busy;
  logic [CntW-1:0]   tmr_count;

  assign rs         = bus.d_rs;
  assign rt         = bus.d_rt;
  assign tuse_rs    = bus.d_tuse_rs;
  assign tuse_rt    = bus.d_tuse_rt;
  assign md_start_e = entry_q[0].valid & entry_q[0].md_start;

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      if (entry_q[k].valid) begin
        if (rs != '0 && entry_q[k].dst == SB_AW_MAX'(rs) &&
            entry_q[k].tnew > SB_TW_MAX'(tuse_rs)) hazard = 1'b1;
        if (rt != '0 && entry_q[k].dst == SB_AW_MAX'(rt) &&
            entry_q[k].tnew > SB_TW_MAX'(tuse_rt)) hazard = 1'b1;
        if (bus.d_eret && entry_q[k].epc_wr) hazard = 1'b1;
      end
    end
    if (bus.d_md_use && (md_start_e || tmr_count != '0)) hazard = 1'b1;
    stall = bus.d_valid & hazard;
  end

  always_comb begin
    entry_d[0] = '0;
    if (bus.d_valid && !stall) begin
      entry_d[0].valid    = 1'b1;
      entry_d[0].dst      = SB_AW_MAX'(bus.d_dst);
      entry_d[0].tnew     = SB_TW_MAX'(bus.d_tnew);
      entry_d[0].epc_wr   = bus.d_epc_wr;
      entry_d[0].md_start = bus.d_md_start;
      entry_d[0].md_op    = bus.d_md_div ? MD_DIV : MD_MUL;
    end
    for (int k = 1; k < int'(NUM_STAGES); k++) begin
      entry_d[k]      = entry_q[k-1];
      entry_d[k].tnew = tnew_age(entry_q[k-1].tnew);
    end
    // Flush kills everything in flight, including the instruction entering E.
    if (bus.flush) begin
      for (int k = 0; k < int'(NUM_STAGES); k++) entry_d[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_STAGES); k++) entry_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_STAGES); k++) entry_q[k] <= entry_d[k];
    end
  end

  md_busy_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk_i    (clk),
    .reset_i  (reset),
    .start_i  (md_start_e),
    .is_div_i (entry_q[0].md_op == MD_DIV),
    .abort_i  (bus.flush),
    .busy_o   (tmr_busy),
    .count_o  (tmr_count)
  );

  assign bus.stall   = stall;
  assign bus.md_busy = tmr_busy;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_d, stall_cycles_q;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && !bus.flush) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline stall unit.
- Keeps an internal shift-register scoreboard of destination register, countdown T_new and EPC-write flag for each in-flight stage after D, so it no longer decodes downstream instruction words.
- Owns the HI/LO multiply/divide busy timer internally and supports exception flush.
- Sits beside the D-stage decoder; its stall output freezes PC/F/D and injects a bubble into E.

Parameters:
- NUM_STAGES, 2: tracked stages after D (1=E, 2=M, ...); range 1..6.
- REG_AW, 5: register address width.
- TNEW_W, 3: width of T_new/T_use fields.
- MUL_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- d_valid  in  1  D holds a real instruction.
- d_rs  in  REG_AW  D source register 1.
- d_rt  in  REG_AW  D source register 2.
- d_tuse_rs  in  TNEW_W  cycles until rs is consumed (7 = unused).
- d_tuse_rt  in  TNEW_W  cycles until rt is consumed (7 = unused).
- d_dst  in  REG_AW  D destination register (0 = none).
- d_tnew  in  TNEW_W  T_new the instruction will have on entering E.
- d_epc_wr  in  1  D is mtc0 to CP0 register 14.
- d_eret  in  1  D is eret.
- d_md_use  in  1  D reads, writes or starts HI/LO.
- d_md_start  in  1  D is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: 1 = div-class, 0 = mul-class.
- flush  in  1  exception/interrupt flush of all tracked stages.
- stall  out  1  freeze F/D, bubble into E.
- md_busy  out  1  MD unit busy (start in E or timer nonzero).

Behaviour:
- Scoreboard entry k (1..NUM_STAGES) holds: valid, dst, tnew, epc_wr, md_start, md_div.
- Reset: all entries cleared, timer = 0, stall = 0, md_busy = 0.
- Every clock, entry k+1 <= entry k with tnew' = (tnew==0) ? 0 : tnew-1; the last entry is dropped.
- Entry 1 load:
  - If stall or !d_valid: bubble (valid = 0).
  - Otherwise: load from D inputs, tnew = d_tnew.
- flush (highest priority): every entry, including the one being loaded, becomes invalid that cycle. The timer is not cleared.
- stall is combinational. It is the OR of the following terms:
  - Register hazard, for each valid k: dst == d_rs, d_rs != 0, tnew_k > d_tuse_rs. Same test for rt.
  - MD hazard: d_md_use & (entry1.valid & entry1.md_start | timer != 0).
  - ERET hazard: d_eret & any valid entry with epc_wr.
  - stall is forced to 0 when d_valid = 0.
- Timer:
  - When entry1 is valid with md_start and no flush, timer loads MUL_CYCLES or DIV_CYCLES (per md_div) on that edge.
  - Otherwise the timer decrements while nonzero.
  - A start in entry1 concurrent with flush is discarded (no load).
- md_busy = entry1.valid & entry1.md_start | timer != 0.
- Boundaries:
  - $0 never causes a hazard.
  - tnew saturates at 0.
  - Simultaneous stall and flush: flush dominates entry state; stall remains combinational.
  - reset mid-division clears the timer immediately.
  - NUM_STAGES = 1: only E is checked.

Optional Feature:
- HAZARD_STATS_EN defined: adds output stall_cycles (32-bit). It increments on each cycle with stall = 1 & !flush, resets to 0, and wraps at 2^32.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - TNEW_W, TUSE_NONE = 7, CP0_EPC = 14.
  - Scoreboard entry struct type.
  - MD op enum (MD_MUL, MD_DIV).
- Sub-module md_busy_timer (start, is_div, abort, busy, count), parameterised by MUL_CYCLES/DIV_CYCLES.

Test Plan:
- Load-use: lw $5 (d_tnew=2) issued, then D addu using $5 (tuse_rs=1) -> stall=1 for 1 cycle, 0 the next; beq using $5 (tuse=0) -> stall for 2 cycles.
- ALU-to-branch: addu $3 (tnew=1) then beq $3 (tuse=0) -> stall 1 cycle. Same sequence with $0 as dst/src -> no stall.
- Divide: div issued, next instruction mfhi -> md_busy=1 for 1+DIV_CYCLES=11 cycles; stall held exactly that long; mult instead -> 6 cycles.
- ERET: mtc0 $14 then eret -> stall while mtc0 is in E or M (NUM_STAGES=2: 2 cycles); mtc0 to $12 -> no stall.
- Flush: lw $5 in E, assert flush, then addu $5 in D -> no stall next cycle. div in E with flush -> timer stays 0, md_busy=0.
- Reset mid-op: assert reset 4 cycles into a div -> md_busy=0, stall=0 asynchronously. With HAZARD_STATS_EN, stall_cycles=0 after reset.
